serial_sub_ctrl: RTL and testbench
==================================

Name: serial_sub_ctrl

Overview:
- Bit-serial subtraction controller. Computes WIDTH-bit A − B − Bin using one shared external 1-bit full-subtractor cell (inputs x, y, z; outputs D, B).
- Loads operands on a start handshake and presents one bit pair plus the registered borrow to the cell per clock, LSB first.
- Collects D into a result shift register, chains B through a borrow flip-flop, and flags completion with a one-cycle done pulse.
- Sits between a requesting sequencer and the full-subtractor datapath cell.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 2..32).
- CNT_W, 5, bit-counter width; must satisfy 2^CNT_W ≥ WIDTH.

Ports:
- clock  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  minuend; captured on accepted start
- b  input  WIDTH  subtrahend; captured on accepted start
- bin  input  1  initial borrow-in; captured on accepted start
- fs_x  output  1  to cell x: current minuend bit
- fs_y  output  1  to cell y: current subtrahend bit
- fs_z  output  1  to cell z: current borrow
- fs_d  input  1  from cell D: difference bit
- fs_b  input  1  from cell B: borrow-out bit
- busy  output  1  high while in RUN
- done  output  1  one-cycle completion pulse
- diff  output  WIDTH  result A − B − Bin (mod 2^WIDTH)
- bout  output  1  final borrow; 1 when A < B + Bin

Behaviour:
- Interface: single clock `clock`; reset `reset_n` is asynchronous, active-low.
- Reset values: state=IDLE; a_sh, b_sh, diff, cnt = 0; borrow_reg=0; busy=0; done=0; bout=0.
- Reset asserted mid-RUN aborts immediately. No done pulse is issued and diff is cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at a clock edge → a_sh←a, b_sh←b, borrow_reg←bin, cnt←0, diff←0, state←RUN.
  - start=0 → stay in IDLE; diff and bout hold their previous result.
- RUN (busy=1):
  - fs_x=a_sh[0], fs_y=b_sh[0], fs_z=borrow_reg. These are purely combinational from registers; the cell is combinational.
  - At each edge: diff←{fs_d, diff[WIDTH-1:1]}; borrow_reg←fs_b; a_sh, b_sh shift right with 0 fill; cnt←cnt+1.
  - When cnt=WIDTH−1 at the edge: final bit is shifted in, bout←fs_b, state←DONE.
- DONE: done=1 for exactly one cycle; busy=0; next edge → IDLE unconditionally.
- fs_x, fs_y, fs_z are driven to 0 outside RUN.
- Latency: start accepted at edge k → bit i processed at edge k+1+i → state DONE after edge k+WIDTH. done is high in the cycle between edges k+WIDTH and k+WIDTH+1. Total WIDTH+1 cycles from acceptance to done.
- The minimum start-to-start spacing is WIDTH+2 cycles.
- Result hold: diff and bout are valid while done=1 and hold until the next accepted start.
- start while busy or in DONE is ignored, with no queuing. Requesters must hold start until they see busy.
- Operand inputs a, b, bin may change freely after acceptance without affecting the operation in flight.
- Arithmetic: diff = (a − b − bin) mod 2^WIDTH; bout is the borrow out of the MSB. No saturation.
- A cnt wrap beyond WIDTH−1 must never occur. An assertion in the bench checks that cnt ≤ WIDTH−1 while in RUN.

Test Plan:
- WIDTH=8, a=5, b=3, bin=0, start pulse → busy for 8 cycles; done 9 cycles after acceptance; diff=2, bout=0.
- a=3, b=5, bin=0 → diff=254 (0xFE), bout=1. a=0, b=0, bin=1 → diff=255, bout=1.
- Exhaustive per-bit check using the real full-subtractor cell: fs_x, fs_y, fs_z, fs_d, fs_b traced each RUN cycle against the truth table (000→D0 B0, 001→D1 B1, 010→D1 B1, 011→D0 B1, 100→D1 B0, 101→D0 B0, 110→D0 B0, 111→D1 B1).
- start held high continuously with a=200, b=100 → only one operation starts. start pulses during RUN and DONE are ignored. diff=100, bout=0. The next operation starts on the first IDLE cycle.
- reset_n driven low at RUN cycle 4 of a=0xAA, b=0x55 → all outputs are 0 immediately and no done pulse appears. After release, a=0xAA, b=0x55 gives diff=0x55, bout=0.
- Back-to-back: start re-asserted immediately after done with a=0xFF, b=0x01, bin=1 → accepted in IDLE; diff=0xFD, bout=0. The previous result holds until acceptance.

Source files
------------

// File: rtl/serial_sub_ctrl.sv
// Bit-serial A - B - Bin controller driving an external combinational 1-bit full-subtractor cell.
// Latency WIDTH+1 cycles from accepted start to done; start is ignored outside IDLE (no queuing).
module serial_sub_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 5
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             fs_x,
  output logic             fs_y,
  output logic             fs_z,
  input  logic             fs_d,
  input  logic             fs_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             borrow_q, borrow_d;
  logic             bout_q, bout_d;

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    bout_d   = bout_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_sh_d   = a;
          b_sh_d   = b;
          borrow_d = bin;
          cnt_d    = '0;
          diff_d   = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        // Result fills from the MSB end so bit 0 lands at diff[0] after WIDTH shifts.
        diff_d   = {fs_d, diff_q[WIDTH-1:1]};
        borrow_d = fs_b;
        a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          bout_d  = fs_b;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
    end
  end

  // Cell inputs are gated so the shared cell sees a quiet 0 pattern outside RUN.
  assign fs_x = (state_q == S_RUN) ? a_sh_q[0] : 1'b0;
  assign fs_y = (state_q == S_RUN) ? b_sh_q[0] : 1'b0;
  assign fs_z = (state_q == S_RUN) ? borrow_q  : 1'b0;

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Scoreboard bench for serial_sub_ctrl with a truth-table full-subtractor cell attached.
module tb_serial_sub_ctrl;

  localparam int W = 8;
  localparam logic [7:0] TT_D = 8'b1001_0110;
  localparam logic [7:0] TT_B = 8'b1000_1110;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         bin;
  logic         fs_x, fs_y, fs_z, fs_d, fs_b;
  logic         busy, done, bout;
  logic [W-1:0] diff;

  typedef struct packed {
    logic [W-1:0] d;
    logic         b;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   busy_run = 0;
  logic [W-1:0] cur_a, cur_b;
  logic         cur_bin;

  always #5 clock = ~clock;

  assign fs_d = TT_D[{fs_x, fs_y, fs_z}];
  assign fs_b = TT_B[{fs_x, fs_y, fs_z}];

  serial_sub_ctrl #(.WIDTH(W), .CNT_W(5)) dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .a(a), .b(b), .bin(bin),
    .fs_x(fs_x), .fs_y(fs_y), .fs_z(fs_z), .fs_d(fs_d), .fs_b(fs_b),
    .busy(busy), .done(done), .diff(diff), .bout(bout)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: per-bit cell traffic during RUN, result pop on done.
  always @(negedge clock) begin
    if (!reset_n) begin
      busy_run = 0;
    end else if (busy) begin
      int i;
      int mask;
      int bor;
      int full;
      i    = busy_run;
      mask = (1 << i) - 1;
      bor  = ((int'(cur_a) & mask) < ((int'(cur_b) & mask) + int'(cur_bin))) ? 1 : 0;
      full = (int'(cur_a) - int'(cur_b) - int'(cur_bin)) & 32'hFF;
      if (i < W) begin
        check($sformatf("fs_x bit%0d", i), int'(fs_x), int'(cur_a[i]));
        check($sformatf("fs_y bit%0d", i), int'(fs_y), int'(cur_b[i]));
        check($sformatf("fs_z bit%0d", i), int'(fs_z), bor);
        check($sformatf("fs_d bit%0d", i), int'(fs_d), (full >> i) & 1);
      end
      total++;
      assert (dut.cnt_q <= 5'(W - 1)) else begin
        bad++;
        $display("FAIL cnt_range: got %0d expected <= %0d", dut.cnt_q, W - 1);
      end
      busy_run++;
    end else begin
      check("cell_inputs_idle", int'({fs_x, fs_y, fs_z}), 0);
      if (done) begin
        check("busy_cycles", busy_run, W);
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got done=1 expected no pending op");
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("diff", int'(diff), int'(e.d));
          check("bout", int'(bout), int'(e.b));
        end
      end
      busy_run = 0;
    end
  end

  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin,
                       input logic [W-1:0] ed, input logic eb);
    @(negedge clock);
    a = ia; b = ib; bin = ibin; start = 1'b1;
    cur_a = ia; cur_b = ib; cur_bin = ibin;
    sb.push_back('{d: ed, b: eb});
    @(posedge clock);
    #1;
    check("accept_busy", int'(busy), 1);
    start = 1'b0;
    a = ~ia; b = ~ib; bin = ~ibin;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!done && n < 40);
    if (!done) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got no done expected done within 40 cycles");
    end
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    cur_a = '0; cur_b = '0; cur_bin = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_diff", int'(diff), 0);
    check("rst_bout", int'(bout), 0);
    reset_n = 1'b1;
    @(negedge clock);

    issue(8'd5, 8'd3, 1'b0, 8'd2, 1'b0);     wait_done();
    issue(8'd3, 8'd5, 1'b0, 8'hFE, 1'b1);    wait_done();
    issue(8'd0, 8'd0, 1'b1, 8'hFF, 1'b1);    wait_done();

    // start held high: exactly one op per IDLE window
    @(negedge clock);
    a = 8'd200; b = 8'd100; bin = 1'b0; start = 1'b1;
    cur_a = 8'd200; cur_b = 8'd100; cur_bin = 1'b0;
    sb.push_back('{d: 8'd100, b: 1'b0});
    @(posedge clock); #1;
    check("held_accept", int'(busy), 1);
    wait_done();
    @(negedge clock);
    check("held_idle_busy", int'(busy), 0);
    check("held_idle_done", int'(done), 0);
    sb.push_back('{d: 8'd100, b: 1'b0});
    @(posedge clock); #1;
    check("held_restart", int'(busy), 1);
    start = 1'b0; a = 8'h3C; b = 8'h0F;
    wait_done();

    // Abort mid-RUN
    issue(8'hAA, 8'h55, 1'b0, 8'h55, 1'b0);
    repeat (3) @(negedge clock);
    @(posedge clock); #1;
    reset_n = 1'b0;
    #1;
    sb.delete();
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_diff", int'(diff), 0);
    check("abort_bout", int'(bout), 0);
    check("abort_cell", int'({fs_x, fs_y, fs_z}), 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge clock);
      check("abort_no_done", int'(done), 0);
    end
    issue(8'hAA, 8'h55, 1'b0, 8'h55, 1'b0);  wait_done();

    // Back-to-back: start raised during DONE, accepted on the following IDLE cycle
    a = 8'hFF; b = 8'h01; bin = 1'b1; start = 1'b1;
    cur_a = 8'hFF; cur_b = 8'h01; cur_bin = 1'b1;
    sb.push_back('{d: 8'hFD, b: 1'b0});
    @(negedge clock);
    check("b2b_idle_busy", int'(busy), 0);
    check("b2b_hold_diff", int'(diff), 8'h55);
    check("b2b_hold_bout", int'(bout), 0);
    @(posedge clock); #1;
    check("b2b_accept", int'(busy), 1);
    start = 1'b0; a = 8'h00; b = 8'h00; bin = 1'b0;
    wait_done();

    repeat (3) @(negedge clock);
    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got no finish expected finish before 20000");
    $fatal(1, "watchdog");
  end

endmodule
